// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch PC sequencer with pre-decode, static branch prediction and a return address stack.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] fetch_pc,
  output logic        fetch_req,
  input  logic        imem_valid,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_stall,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_target
);
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);
  typedef enum logic {RUN, WAIT_JALR} state_t;
  state_t state;
  logic [31:0] pc, pc4, b_imm, j_imm, target;
  logic [31:0] ras [RAS_DEPTH];
  logic [AW-1:0] top, top_m1;
  logic [AW:0] cnt;
  logic [6:0] op;
  logic [4:0] rd, rs1;
  logic [2:0] f3;
  logic is_br, is_jal, is_jalr, br_tk, push, pop, taken, stall_jalr, hold, accept;
  assign op = imem_inst[6:0];
  assign rd = imem_inst[11:7];
  assign f3 = imem_inst[14:12];
  assign rs1 = imem_inst[19:15];
  assign pc4 = pc + 32'd4;
  assign b_imm = {{20{imem_inst[31]}}, imem_inst[7], imem_inst[30:25], imem_inst[11:8], 1'b0};
  assign j_imm = {{12{imem_inst[31]}}, imem_inst[19:12], imem_inst[20], imem_inst[30:21], 1'b0};
  assign top_m1 = top - 1'b1;
  assign is_br = op == 7'h63 && f3[2:1] != 2'b01;
  assign is_jal = op == 7'h6f;
  assign is_jalr = op == 7'h67 && f3 == 3'b000;
  assign br_tk = is_br && imem_inst[31];
  assign pop = is_jalr && rd == 5'd0 && rs1 == 5'd1 && |cnt;
  assign push = (is_jal || is_jalr) && rd == 5'd1;
  assign taken = br_tk || is_jal || pop;
  assign target = br_tk ? pc + b_imm : is_jal ? pc + j_imm : pop ? ras[top_m1] : pc4;
  // JALRs not predicted by the RAS park the fetcher until the backend resolves them
  assign stall_jalr = is_jalr && !pop;
  assign hold = out_valid && out_stall;
  assign accept = state == RUN && imem_valid && !hold && !redirect_valid;
  assign fetch_pc = pc;
  assign fetch_req = state == RUN && !hold;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
      state <= RUN;
      top <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_inst <= '0;
      out_pc <= '0;
      out_pred_taken <= 1'b0;
      out_pred_target <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      out_valid <= 1'b0;
      state <= RUN;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_inst <= imem_inst;
      out_pc <= pc;
      out_pred_taken <= taken;
      out_pred_target <= target;
      pc <= target;
      state <= stall_jalr ? WAIT_JALR : RUN;
      if (push) begin
        top <= top + 1'b1;
        cnt <= cnt == FULL ? cnt : cnt + 1'b1;
      end else if (pop) begin
        top <= top_m1;
        cnt <= cnt - 1'b1;
      end
    end else if (!out_stall) begin
      out_valid <= 1'b0;
    end
  end
  // a push into a full stack lands on the oldest slot since top wraps
  always_ff @(posedge clock) begin
    if (!reset && accept && push) ras[top] <= pc4;
  end
endmodule
